// File: rtl/rbot_pkg.sv
// Shared robot definitions: move codes, face-to-motor mapping, executor state encoding
// and the move-code decoder.
package rbot_pkg;

    localparam int unsigned NUM_MOTORS  = 6;
    localparam int unsigned MOVE_CODE_W = 4;
    localparam int unsigned MOTOR_IDX_W = 3;
    localparam int unsigned STEP_CNT_W  = 8;

    typedef logic [MOVE_CODE_W-1:0] move_code_t;
    typedef logic [NUM_MOTORS-1:0]  motor_vec_t;
    typedef logic [MOTOR_IDX_W-1:0] motor_idx_t;

    // Clockwise codes occupy 1..6 and counter-clockwise codes 7..12, both in U,D,F,B,L,R order
    localparam move_code_t MOVE_U_CW  = 4'd1;
    localparam move_code_t MOVE_R_CW  = 4'd6;
    localparam move_code_t MOVE_U_CCW = 4'd7;
    localparam move_code_t MOVE_R_CCW = 4'd12;

    localparam motor_idx_t FACE_U = 3'd0;
    localparam motor_idx_t FACE_D = 3'd1;
    localparam motor_idx_t FACE_F = 3'd2;
    localparam motor_idx_t FACE_B = 3'd3;
    localparam motor_idx_t FACE_L = 3'd4;
    localparam motor_idx_t FACE_R = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STEP_HIGH,
        ST_STEP_LOW,
        ST_SETTLE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       cw;
        motor_idx_t motor;
    } move_decode_t;

    function automatic motor_idx_t face_motor(input logic [2:0] face_ofs);
        case (face_ofs)
            3'd0:    return FACE_U;
            3'd1:    return FACE_D;
            3'd2:    return FACE_F;
            3'd3:    return FACE_B;
            3'd4:    return FACE_L;
            default: return FACE_R;
        endcase
    endfunction

    function automatic move_decode_t decode_move(input move_code_t code);
        move_decode_t d;
        d = '0;
        if (code >= MOVE_U_CW && code <= MOVE_R_CW) begin
            d.valid = 1'b1;
            d.cw    = 1'b1;
            d.motor = face_motor(3'(code - MOVE_U_CW));
        end else if (code >= MOVE_U_CCW && code <= MOVE_R_CCW) begin
            d.valid = 1'b1;
            d.cw    = 1'b0;
            d.motor = face_motor(3'(code - MOVE_U_CCW));
        end
        return d;
    endfunction

    function automatic motor_vec_t motor_onehot(input motor_idx_t idx);
        return motor_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/move_executor_if.sv
// Sequencer <-> move executor handshake and stepper-driver outputs.
interface move_executor_if;
    import rbot_pkg::*;

    logic       start_move;
    move_code_t next_move;
    logic       move_done;
    logic       move_error;
    logic       busy;
    motor_vec_t motor_en;
    motor_vec_t step;
    motor_vec_t dir;

    modport master (
        output start_move, next_move,
        input  move_done, move_error, busy, motor_en, step, dir
    );

    modport slave (
        input  start_move, next_move,
        output move_done, move_error, busy, motor_en, step, dir
    );
endinterface

// File: rtl/step_timer.sv
// Loadable down-counter; tc_c flags the last cycle of the loaded interval.
module step_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             tc_c
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (enable && count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign tc_c = enable && (count_q == WIDTH'(1));
endmodule

// File: rtl/move_executor.sv
// Executes one 90-degree face turn: direction setup, a burst of step pulses, settle dwell,
// then a one-cycle completion pulse.
module move_executor
    import rbot_pkg::*;
#(
    parameter int unsigned HALF_PERIOD       = 25000,
    parameter int unsigned STEPS_PER_QUARTER = 50,
    parameter int unsigned SETTLE_CYCLES     = 100000
) (
    input  logic          clock,
    input  logic          reset,
    move_executor_if.slave mv
);
    localparam int unsigned MAX_INTERVAL = (HALF_PERIOD > SETTLE_CYCLES) ? HALF_PERIOD : SETTLE_CYCLES;
    localparam int unsigned TIMER_W      = $clog2(MAX_INTERVAL + 1);

    localparam logic [TIMER_W-1:0]    HALF_LOAD   = TIMER_W'(HALF_PERIOD);
    localparam logic [TIMER_W-1:0]    SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES);
    localparam logic [STEP_CNT_W-1:0] STEP_LIMIT  = STEP_CNT_W'(STEPS_PER_QUARTER);

    state_t                  state_q, state_d;
    logic [STEP_CNT_W-1:0]   step_cnt_q, step_cnt_d;
    motor_vec_t              motor_en_q, motor_en_d;
    motor_vec_t              dir_q, dir_d;
    motor_vec_t              step_q, step_d;
    logic                    error_q, error_d;
    logic                    done_q, done_d;
    logic                    move_error_q, move_error_d;
    logic                    busy_q, busy_d;
    logic                    timer_load, timer_en, timer_tc_c;
    logic [TIMER_W-1:0]      timer_value;
    move_decode_t            dec;

    step_timer #(.WIDTH(TIMER_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (timer_en),
        .tc_c       (timer_tc_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            step_cnt_q   <= '0;
            motor_en_q   <= '0;
            dir_q        <= '0;
            step_q       <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            move_error_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            motor_en_q   <= motor_en_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            error_q      <= error_d;
            done_q       <= done_d;
            move_error_q <= move_error_d;
            busy_q       <= busy_d;
        end
    end

    // Next state plus next values of every registered output, derived from the next state
    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        motor_en_d  = motor_en_q;
        dir_d       = dir_q;
        error_d     = error_q;
        timer_load  = 1'b0;
        timer_value = '0;
        timer_en    = 1'b0;
        dec         = decode_move(mv.next_move);

        case (state_q)
            ST_IDLE: begin
                if (mv.start_move) begin
                    step_cnt_d = '0;
                    timer_load = 1'b1;
                    if (dec.valid) begin
                        motor_en_d  = motor_onehot(dec.motor);
                        dir_d       = dec.cw ? motor_onehot(dec.motor) : '0;
                        error_d     = 1'b0;
                        timer_value = HALF_LOAD;
                        state_d     = ST_SETUP;
                    end else begin
                        motor_en_d  = '0;
                        dir_d       = '0;
                        error_d     = 1'b1;
                        timer_value = SETTLE_LOAD;
                        state_d     = ST_SETTLE;
                    end
                end
            end
            ST_SETUP, ST_STEP_HIGH: begin
                timer_en = 1'b1;
                if (timer_tc_c) begin
                    timer_load  = 1'b1;
                    timer_value = HALF_LOAD;
                    state_d     = (state_q == ST_SETUP) ? ST_STEP_HIGH : ST_STEP_LOW;
                end
            end
            ST_STEP_LOW: begin
                timer_en = 1'b1;
                if (timer_tc_c) begin
                    step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
                    timer_load = 1'b1;
                    if (step_cnt_d < STEP_LIMIT) begin
                        timer_value = HALF_LOAD;
                        state_d     = ST_STEP_HIGH;
                    end else begin
                        timer_value = SETTLE_LOAD;
                        state_d     = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                timer_en = 1'b1;
                if (timer_tc_c) begin
                    motor_en_d = '0;
                    dir_d      = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        step_d       = (state_d == ST_STEP_HIGH) ? motor_en_d : '0;
        done_d       = (state_d == ST_DONE);
        move_error_d = done_d && error_d;
        busy_d       = (state_d != ST_IDLE);
    end

    assign mv.motor_en   = motor_en_q;
    assign mv.dir        = dir_q;
    assign mv.step       = step_q;
    assign mv.move_done  = done_q;
    assign mv.move_error = move_error_q;
    assign mv.busy       = busy_q;
endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 Parameter HALF_PERIOD, default 25000: clock cycles per step-pulse half (2 kHz step rate at 100 MHz); SHALL be >= 1.
REQ-002 Parameter STEPS_PER_QUARTER, default 50: step pulses per 90-degree face turn; SHALL be 1..255.
REQ-003 Parameter SETTLE_CYCLES, default 100000: post-move dwell before completion; SHALL be >= 2.
REQ-004 clock  input  1  system clock; reset reset, synchronous, active-high; clock clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start_move  input  1  single-cycle request strobe from the move sequencer.
REQ-007 next_move  input  4  move code, valid in the start_move cycle.
REQ-008 move_done  output  1  single-cycle completion pulse back to the sequencer.
REQ-009 move_error  output  1  high with move_done when the code was invalid.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 motor_en  output  6  one-hot stepper-driver enable, active-high.
REQ-012 step  output  6  one-hot step pulse to selected driver.
REQ-013 dir  output  6  direction to selected driver; 1 = clockwise; unselected bits 0.

Function
REQ-014 Move codes SHALL decode: 1..6 = U,D,F,B,L,R clockwise (motor index 0..5); 7..12 = same faces counter-clockwise; 0 and 13..15 invalid.
REQ-015 States SHALL be IDLE, SETUP, STEP_HIGH, STEP_LOW, SETTLE, DONE.
REQ-016 IDLE: start_move=1 with valid code -> latch code, load motor_en/dir, go SETUP; invalid code -> go SETTLE with motor_en=0.
REQ-017 start_move SHALL be sampled only in IDLE; strobes in any other state (including DONE) are ignored, never queued.
REQ-018 SETUP SHALL last HALF_PERIOD cycles (driver direction setup time), step=0, then STEP_HIGH.
REQ-019 STEP_HIGH SHALL last HALF_PERIOD cycles with step[sel]=1; STEP_LOW HALF_PERIOD cycles with step=0.
REQ-020 After STEP_LOW, 8-bit step counter increments; < STEPS_PER_QUARTER -> STEP_HIGH, else SETTLE.
REQ-021 SETTLE SHALL last SETTLE_CYCLES cycles, motor_en held, step=0; then DONE.
REQ-022 DONE SHALL last exactly one cycle: move_done=1, move_error=1 iff invalid code, motor_en=dir=0, then IDLE.
REQ-023 Valid-move latency: move_done high exactly HALF_PERIOD + 2*HALF_PERIOD*STEPS_PER_QUARTER + SETTLE_CYCLES + 1 cycles after the start_move sample cycle.
REQ-024 Invalid-move latency: move_done high exactly SETTLE_CYCLES + 1 cycles after sample; no step or motor_en activity.
REQ-025 Minimum latency SHALL be >= 3 cycles so the sequencer, which samples move_done from its second post-strobe cycle, never misses it.
REQ-026 motor_en, dir, step SHALL be registered, glitch-free, at most one bit high each.
REQ-027 Timer SHALL be a down-counter wide enough for max(HALF_PERIOD, SETTLE_CYCLES); terminal count advances state.

Reset
REQ-028 Reset SHALL force IDLE, step counter 0, timer 0, and all outputs 0 on the next clock edge.
REQ-029 Reset mid-move SHALL abort with no move_done pulse; motor_en drops on that edge.
REQ-030 reset has priority over start_move in the same cycle.

Structure
REQ-031 Move-code constants, face-to-motor index, and state encoding SHALL live in shared package rbot_pkg.
REQ-032 One sub-module step_timer (load value, enable, terminal-count pulse) SHALL implement all interval timing.

Verification (HALF_PERIOD=2, STEPS_PER_QUARTER=3, SETTLE_CYCLES=4)
REQ-033 start_move with code 3 at cycle 0 -> motor_en=6'b000100, dir=6'b000100; step[2] rises cycle 3, three 2-high/2-low pulses; move_done cycle 19, move_error=0.
REQ-034 Code 9 -> motor_en=dir-free 6'b000100 with dir=0; three pulses on step[2]; move_done cycle 19.
REQ-035 Code 14 -> no motor_en/step activity; move_done and move_error at cycle 5.
REQ-036 start_move with code 1 at cycles 4 and 19 of an active move -> ignored; exactly one move_done, IDLE after.
REQ-037 reset at cycle 8 of a valid move -> all outputs 0 at cycle 9, no move_done; new move then completes normally.
REQ-038 Back-to-back with sequencer model: 4-move queue (1,7,12,6) -> four move_done pulses, correct one-hot per move, no overlap.
